// File: rtl/palin_pkg.sv
// Shared definitions for the palindrome digit feeder and detector: widths,
// FSM state encoding and digit extraction helpers.
package palin_pkg;

    localparam int DIGIT_W      = 4;
    localparam int NUM_DIGITS   = 16;
    localparam int SEQ_W        = DIGIT_W * NUM_DIGITS;
    localparam int LEN_W        = 4;
    localparam int CLEAR_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Digit 0 lives in the most significant nibble of the packed sequence.
    function automatic logic [DIGIT_W-1:0] head_digit(input logic [SEQ_W-1:0] seq);
        return seq[SEQ_W-1 -: DIGIT_W];
    endfunction

    function automatic logic [SEQ_W-1:0] drop_head(input logic [SEQ_W-1:0] seq);
        return {seq[SEQ_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
    endfunction

endpackage

// File: rtl/palindrome_digit_feeder_rise_detect.sv
// Rising-edge detector: keeps the previous input sample in a register and
// flags the cycle in which the input is high but was low on the prior edge.
module rise_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    // Previous-sample register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/palindrome_digit_feeder.sv
// Captures a packed digit sequence on a start edge, pulses the detector clear,
// then streams the digits MSB-nibble first, one per clock, with valid/last flags.
module palindrome_digit_feeder
    import palin_pkg::*;
#(
    parameter int CLEAR_CYCLES_P = palin_pkg::CLEAR_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_len_in,
    input  logic [SEQ_W-1:0]   i_seq_in,
    output logic [DIGIT_W-1:0] o_digit_out,
    output logic               o_digit_valid,
    output logic               o_digit_last,
    output logic               o_det_clear,
    output logic [LEN_W-1:0]   o_len_out,
    output logic [LEN_W-1:0]   o_sent_count,
    output logic               o_busy
);

    localparam int                CLR_W    = $clog2(CLEAR_CYCLES_P) + 1;
    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLEAR_CYCLES_P - 1);

    state_t             r_state;
    logic [SEQ_W-1:0]   r_shadow;
    logic [CLR_W-1:0]   r_clr_cnt;
    logic [DIGIT_W-1:0] r_digit;
    logic               r_valid;
    logic               r_last;
    logic               r_det_clear;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_sent;
    logic               r_busy;

    state_t             w_state;
    logic [SEQ_W-1:0]   w_shadow;
    logic [CLR_W-1:0]   w_clr_cnt;
    logic [DIGIT_W-1:0] w_digit;
    logic               w_valid;
    logic               w_last;
    logic               w_det_clear;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_sent;
    logic               w_busy;
    logic               w_trigger;
    logic [LEN_W-1:0]   w_sent_inc;

    rise_detect u_rise_detect (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_start),
        .o_rise  (w_trigger)
    );

    // r_sent never exceeds 14 while streaming, so the increment cannot wrap.
    assign w_sent_inc = r_sent + LEN_W'(1);

    // State and registered-output update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_clr_cnt   <= '0;
            r_digit     <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_det_clear <= 1'b0;
            r_len       <= '0;
            r_sent      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_shadow    <= w_shadow;
            r_clr_cnt   <= w_clr_cnt;
            r_digit     <= w_digit;
            r_valid     <= w_valid;
            r_last      <= w_last;
            r_det_clear <= w_det_clear;
            r_len       <= w_len;
            r_sent      <= w_sent;
            r_busy      <= w_busy;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so they leave registers.
    always_comb begin
        w_state     = r_state;
        w_shadow    = r_shadow;
        w_clr_cnt   = r_clr_cnt;
        w_digit     = r_digit;
        w_valid     = r_valid;
        w_last      = r_last;
        w_det_clear = r_det_clear;
        w_len       = r_len;
        w_sent      = r_sent;
        w_busy      = r_busy;

        case (r_state)
            IDLE, DONE: begin
                if (w_trigger) begin
                    w_state     = CLEAR;
                    w_shadow    = i_seq_in;
                    w_len       = i_len_in;
                    w_sent      = '0;
                    w_clr_cnt   = '0;
                    w_det_clear = 1'b1;
                    w_busy      = 1'b1;
                    w_valid     = 1'b0;
                    w_digit     = '0;
                    w_last      = 1'b0;
                end else begin
                    w_det_clear = 1'b0;
                    w_busy      = 1'b0;
                    w_valid     = 1'b0;
                    w_digit     = '0;
                    w_last      = 1'b0;
                end
            end

            CLEAR: begin
                if (r_clr_cnt == CLR_LAST) begin
                    w_det_clear = 1'b0;
                    w_clr_cnt   = '0;
                    if (r_len == LEN_W'(0)) begin
                        w_state = DONE;
                        w_busy  = 1'b0;
                    end else begin
                        w_state  = STREAM;
                        w_valid  = 1'b1;
                        w_digit  = head_digit(r_shadow);
                        w_last   = (r_len == LEN_W'(1));
                        w_shadow = drop_head(r_shadow);
                    end
                end else begin
                    w_clr_cnt = r_clr_cnt + CLR_W'(1);
                end
            end

            STREAM: begin
                w_sent = (r_sent == r_len) ? r_sent : w_sent_inc;
                if (w_sent_inc == r_len) begin
                    w_state = DONE;
                    w_valid = 1'b0;
                    w_digit = '0;
                    w_last  = 1'b0;
                    w_busy  = 1'b0;
                end else begin
                    w_valid  = 1'b1;
                    w_digit  = head_digit(r_shadow);
                    w_last   = (w_sent_inc == (r_len - LEN_W'(1)));
                    w_shadow = drop_head(r_shadow);
                end
            end

            default: begin
                w_state     = IDLE;
                w_valid     = 1'b0;
                w_digit     = '0;
                w_last      = 1'b0;
                w_det_clear = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    assign o_digit_out   = r_digit;
    assign o_digit_valid = r_valid;
    assign o_digit_last  = r_last;
    assign o_det_clear   = r_det_clear;
    assign o_len_out     = r_len;
    assign o_sent_count  = r_sent;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_palindrome_digit_feeder.sv
// Directed, table-driven bench for palindrome_digit_feeder with hand-computed
// digit streams plus hand-written reset and held-start sequences.
module tb_palindrome_digit_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  len_in;
    logic [63:0] seq_in;
    logic [3:0]  digit_out;
    logic        digit_valid;
    logic        digit_last;
    logic        det_clear;
    logic [3:0]  len_out;
    logic [3:0]  sent_count;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    palindrome_digit_feeder dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_len_in      (len_in),
        .i_seq_in      (seq_in),
        .o_digit_out   (digit_out),
        .o_digit_valid (digit_valid),
        .o_digit_last  (digit_last),
        .o_det_clear   (det_clear),
        .o_len_out     (len_out),
        .o_sent_count  (sent_count),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  len;
        logic [63:0] seq;
        logic [63:0] exp_dig;
        int          glitch;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_valid"}, 64'(digit_valid), 64'd0);
        check({nm, "_digit"}, 64'(digit_out), 64'd0);
        check({nm, "_last"},  64'(digit_last), 64'd0);
        check({nm, "_clear"}, 64'(det_clear), 64'd0);
        check({nm, "_busy"},  64'(busy), 64'd0);
    endtask

    // One full run; start rises at the edge after this call and drops a cycle later.
    task automatic run_vec(input vec_t v);
        logic [63:0] ed;
        ed = v.exp_dig;
        @(negedge clk);
        len_in = v.len;
        seq_in = v.seq;
        start  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start  = 1'b0;
                seq_in = 64'hFFFF_FFFF_FFFF_FFFF;
                len_in = 4'd9;
            end
            check({v.name, "_clear"}, 64'(det_clear), 64'd1);
            check({v.name, "_cbusy"}, 64'(busy), 64'd1);
            check({v.name, "_cvalid"}, 64'(digit_valid), 64'd0);
        end
        for (int k = 0; k < int'(v.len); k++) begin
            @(negedge clk);
            start = (k == v.glitch) ? 1'b1 : 1'b0;
            check({v.name, "_valid"}, 64'(digit_valid), 64'd1);
            check({v.name, "_digit"}, 64'(digit_out), 64'(ed[63 - 4*k -: 4]));
            check({v.name, "_last"},  64'(digit_last), 64'(k == int'(v.len) - 1));
            check({v.name, "_sent"},  64'(sent_count), 64'(k));
            check({v.name, "_sclear"}, 64'(det_clear), 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        check_idle_outputs({v.name, "_done"});
        check({v.name, "_dsent"}, 64'(sent_count), 64'(v.len));
        check({v.name, "_dlen"},  64'(len_out), 64'(v.len));
        @(negedge clk);
        check_idle_outputs({v.name, "_post"});
    endtask

    initial begin
        vecs[0] = '{"p12321", 4'd5,  64'h1232100000000000, 64'h1232100000000000, -1};
        vecs[1] = '{"abba",   4'd4,  64'hABBA000000000000, 64'hABBA000000000000, -1};
        vecs[2] = '{"len0",   4'd0,  64'h9999999999999999, 64'h0,                -1};
        vecs[3] = '{"glitch", 4'd5,  64'h1234500000000000, 64'h1234500000000000,  2};
        vecs[4] = '{"abba2",  4'd4,  64'hABBAC00000000000, 64'hABBA000000000000, -1};
        vecs[5] = '{"len15",  4'd15, 64'h0123456789ABCDEF, 64'h0123456789ABCDE0, -1};
        vecs[6] = '{"len1",   4'd1,  64'h7654321000000000, 64'h7000000000000000, -1};

        reset  = 1'b1;
        start  = 1'b0;
        len_in = 4'd0;
        seq_in = 64'h0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_len",  64'(len_out), 64'd0);
        check("reset_sent", 64'(sent_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Reset mid-stream after two digits.
        len_in = 4'd5;
        seq_in = 64'h1234500000000000;
        start  = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_d1", 64'(digit_out), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("rstmid");
        check("rstmid_len",  64'(len_out), 64'd0);
        check("rstmid_sent", 64'(sent_count), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("rstmid_quiet", 64'(det_clear | digit_valid | busy), 64'd0);
        end

        // Reset coincident with a start edge: no run may begin.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_idle_outputs("rststart");
        repeat (5) begin
            @(negedge clk);
            check("rststart_quiet", 64'(det_clear | digit_valid | busy), 64'd0);
        end

        // Start held high for 50 cycles produces exactly one run of three digits.
        begin
            int n_clear;
            int n_valid;
            n_clear = 0;
            n_valid = 0;
            len_in  = 4'd3;
            seq_in  = 64'h5A5000000000000F;
            start   = 1'b1;
            repeat (50) begin
                @(negedge clk);
                if (det_clear) n_clear++;
                if (digit_valid) n_valid++;
            end
            start = 1'b0;
            check("held_clear_cycles", 64'(n_clear), 64'd2);
            check("held_valid_cycles", 64'(n_valid), 64'd3);
            check("held_sent", 64'(sent_count), 64'd3);
            check_idle_outputs("held_end");
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
